// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-port signals of the port A arbiter.
// master = requesters plus memory model, slave = arbiter.
interface mem_port_arbiter_if;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0][31:0] req_addr;
    logic [1:0]       req_wen;
    logic [1:0][2:0]  req_sel;
    logic [1:0][31:0] req_wdata;
    logic [1:0]       resp_valid;
    logic [1:0]       resp_ready;
    logic [31:0]      resp_rdata;
    logic             resp_err;
    logic [31:0]      mem_addr;
    logic [2:0]       mem_sel;
    logic             mem_wen;
    logic [31:0]      mem_wdata;
    logic [31:0]      mem_rdata;

    modport master (
        output req_valid, req_addr, req_wen, req_sel, req_wdata, resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_addr, mem_sel, mem_wen, mem_wdata
    );

    modport slave (
        input  req_valid, req_addr, req_wen, req_sel, req_wdata, resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_addr, mem_sel, mem_wen, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter and one-shot access sequencer for memory port A.
// Illegal accesses are answered with an error and never drive the memory.
module mem_port_arbiter #(
    parameter int unsigned ADDR_LIMIT = 512
) (
    input logic                clk,
    input logic                rst_n,
    mem_port_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP, ERR} state_t;

    state_t      state, state_nxt;
    logic        last_grant;
    logic        grant;
    logic        accept;
    logic        legal;
    logic [31:0] cur_addr;
    logic [2:0]  cur_sel;
    logic        cur_wen;
    logic [2:0]  size;
    logic [32:0] end_addr;

    logic        idx;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  sel_q;
    logic        wen_q;

    logic [1:0]  req_ready;
    logic [1:0]  resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_wen;

    // With both requesting, the one not granted last wins.
    always_comb begin
        if (bus.req_valid == 2'b11) begin
            grant = ~last_grant;
        end else begin
            grant = ~bus.req_valid[0];
        end
        cur_addr = bus.req_addr[grant];
        cur_sel  = bus.req_sel[grant];
        cur_wen  = bus.req_wen[grant];
        accept   = (state == IDLE) && rst_n && bus.req_valid[grant];
    end

    always_comb begin
        legal = 1'b1;
        size  = 3'd1;
        case (cur_sel)
            3'b000: size = 3'd1;
            3'b100: begin
                size = 3'd1;
                if (cur_wen) legal = 1'b0;
            end
            3'b001: begin
                size = 3'd2;
                if (cur_addr[0]) legal = 1'b0;
            end
            3'b101: begin
                size = 3'd2;
                if (cur_wen || cur_addr[0]) legal = 1'b0;
            end
            3'b010: begin
                size = 3'd4;
                if (cur_addr[1:0] != 2'b00) legal = 1'b0;
            end
            default: legal = 1'b0;
        endcase
        // 33-bit sum so addresses near 2^32 cannot wrap into range.
        end_addr = {1'b0, cur_addr} + {30'd0, size};
        if (end_addr > 33'(ADDR_LIMIT)) legal = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            idx        <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            sel_q      <= '0;
            wen_q      <= 1'b0;
        end else if (accept) begin
            last_grant <= grant;
            idx        <= grant;
            addr_q     <= cur_addr;
            wdata_q    <= bus.req_wdata[grant];
            sel_q      <= cur_sel;
            wen_q      <= cur_wen;
        end
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = '0;
        resp_valid = '0;
        resp_rdata = '0;
        resp_err   = 1'b0;
        mem_wen    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    req_ready[grant] = 1'b1;
                    state_nxt        = legal ? ISSUE : ERR;
                end
            end
            ISSUE: begin
                // Reset landing on the issue cycle must suppress the write.
                mem_wen   = wen_q & rst_n;
                state_nxt = RESP;
            end
            RESP: begin
                resp_valid[idx] = 1'b1;
                resp_rdata      = wen_q ? '0 : bus.mem_rdata;
                if (bus.resp_ready[idx]) state_nxt = IDLE;
            end
            ERR: begin
                resp_valid[idx] = 1'b1;
                resp_err        = 1'b1;
                if (bus.resp_ready[idx]) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.req_ready  = req_ready;
    assign bus.resp_valid = resp_valid;
    assign bus.resp_rdata = resp_rdata;
    assign bus.resp_err   = resp_err;
    assign bus.mem_wen    = mem_wen;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_sel    = sel_q;
    assign bus.mem_wdata  = wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a byte-addressed mock memory
// that registers its read data one cycle after the address.
module tb_mem_port_arbiter;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;
    int   wen_count;
    logic [7:0] mem_bytes [512];

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.ADDR_LIMIT(512)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ix(input logic [31:0] a, input int off);
        return int'((a + 32'(off)) & 32'h1FF);
    endfunction

    function automatic logic [31:0] mem_read(input logic [31:0] a, input logic [2:0] s);
        logic [31:0] w;
        w = {mem_bytes[ix(a, 3)], mem_bytes[ix(a, 2)], mem_bytes[ix(a, 1)], mem_bytes[ix(a, 0)]};
        case (s)
            3'b000:  return {{24{w[7]}}, w[7:0]};
            3'b100:  return {24'd0, w[7:0]};
            3'b001:  return {{16{w[15]}}, w[15:0]};
            3'b101:  return {16'd0, w[15:0]};
            default: return w;
        endcase
    endfunction

    always @(posedge clk) begin
        if (bus.mem_wen) begin
            wen_count <= wen_count + 1;
            mem_bytes[ix(bus.mem_addr, 0)] <= bus.mem_wdata[7:0];
            if (bus.mem_sel[1:0] != 2'b00) mem_bytes[ix(bus.mem_addr, 1)] <= bus.mem_wdata[15:8];
            if (bus.mem_sel[1:0] == 2'b10) begin
                mem_bytes[ix(bus.mem_addr, 2)] <= bus.mem_wdata[23:16];
                mem_bytes[ix(bus.mem_addr, 3)] <= bus.mem_wdata[31:24];
            end
        end
        bus.mem_rdata <= mem_read(bus.mem_addr, bus.mem_sel);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic do_access(input int idx, input logic [31:0] addr, input logic [2:0] sel,
                             input logic wen, input logic [31:0] wdata, input logic exp_err,
                             input logic [31:0] exp_rdata, input int hold, input string tag);
        logic [1:0] oh;
        int         wc0;
        int         n;
        oh = (idx == 0) ? 2'b01 : 2'b10;
        @(negedge clk);
        bus.req_addr[idx]  = addr;
        bus.req_sel[idx]   = sel;
        bus.req_wen[idx]   = wen;
        bus.req_wdata[idx] = wdata;
        bus.req_valid      = oh;
        #1;
        n = 0;
        while (bus.req_ready[idx] !== 1'b1 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check({tag, ":req_ready"}, 32'(bus.req_ready), 32'(oh));
        wc0 = wen_count;
        @(negedge clk);
        bus.req_valid = 2'b00;
        #1;
        if (!exp_err) begin
            check({tag, ":issue_wen"}, 32'(bus.mem_wen), 32'(wen));
            check({tag, ":issue_addr"}, bus.mem_addr, addr);
            @(negedge clk);
            #1;
        end
        check({tag, ":resp_valid"}, 32'(bus.resp_valid), 32'(oh));
        check({tag, ":resp_err"}, 32'(bus.resp_err), 32'(exp_err));
        check({tag, ":resp_rdata"}, bus.resp_rdata, exp_rdata);
        check({tag, ":resp_wen"}, 32'(bus.mem_wen), 32'd0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            bus.req_valid = 2'b11;
            #1;
            check($sformatf("%s:hold%0d_valid", tag, h), 32'(bus.resp_valid), 32'(oh));
            check($sformatf("%s:hold%0d_rdata", tag, h), bus.resp_rdata, exp_rdata);
            check($sformatf("%s:hold%0d_ready", tag, h), 32'(bus.req_ready), 32'd0);
        end
        @(negedge clk);
        bus.req_valid  = 2'b00;
        bus.resp_ready = oh;
        @(negedge clk);
        bus.resp_ready = 2'b00;
        #1;
        check({tag, ":idle_valid"}, 32'(bus.resp_valid), 32'd0);
        check({tag, ":wen_cycles"}, 32'(wen_count - wc0), 32'(wen && !exp_err));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [1:0] g_idx [4];
        int         g_cyc [4];
        int         ng;
        int         wc0;

        n_checks       = 0;
        n_pass         = 0;
        wen_count      = 0;
        rst_n          = 1'b0;
        bus.req_valid  = '0;
        bus.req_addr   = '0;
        bus.req_wen    = '0;
        bus.req_sel    = '0;
        bus.req_wdata  = '0;
        bus.resp_ready = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst:req_ready", 32'(bus.req_ready), 32'd0);
        check("rst:resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst:resp_err", 32'(bus.resp_err), 32'd0);
        check("rst:resp_rdata", bus.resp_rdata, 32'd0);
        check("rst:mem_wen", 32'(bus.mem_wen), 32'd0);
        check("rst:mem_addr", bus.mem_addr, 32'd0);
        check("rst:mem_sel", 32'(bus.mem_sel), 32'd0);
        check("rst:mem_wdata", bus.mem_wdata, 32'd0);
        rst_n = 1'b1;

        do_access(0, 32'h10, 3'b010, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0, 0, "sw_10");
        do_access(0, 32'h10, 3'b010, 1'b0, 32'h0, 1'b0, 32'hDEADBEEF, 0, "lw_10");
        do_access(1, 32'h21, 3'b000, 1'b1, 32'h000000AA, 1'b0, 32'h0, 0, "sb_21");
        do_access(1, 32'h21, 3'b100, 1'b0, 32'h0, 1'b0, 32'h000000AA, 0, "lbu_21");

        do_access(0, 32'h02, 3'b010, 1'b0, 32'h0, 1'b1, 32'h0, 0, "lw_mis");
        do_access(0, 32'h40, 3'b100, 1'b1, 32'h1234, 1'b1, 32'h0, 0, "sw_sel100");
        do_access(1, 32'h40, 3'b101, 1'b1, 32'h1234, 1'b1, 32'h0, 0, "st_sel101");
        do_access(0, 32'h40, 3'b011, 1'b0, 32'h0, 1'b1, 32'h0, 0, "sel011");
        do_access(1, 32'h200, 3'b000, 1'b0, 32'h0, 1'b1, 32'h0, 0, "lb_oob");
        do_access(1, 32'h1FF, 3'b001, 1'b0, 32'h0, 1'b1, 32'h0, 0, "lh_mis");
        do_access(0, 32'h1FE, 3'b010, 1'b1, 32'h1, 1'b1, 32'h0, 0, "sw_mis");

        do_access(0, 32'h1FC, 3'b010, 1'b1, 32'h0BADF00D, 1'b0, 32'h0, 0, "sw_top");
        do_access(1, 32'h1FC, 3'b010, 1'b0, 32'h0, 1'b0, 32'h0BADF00D, 0, "lw_top");
        do_access(0, 32'h1FF, 3'b100, 1'b0, 32'h0, 1'b0, 32'h0000000B, 0, "lbu_top");

        do_access(0, 32'h10, 3'b010, 1'b0, 32'h0, 1'b0, 32'hDEADBEEF, 5, "lw_hold");
        do_access(1, 32'h1FE, 3'b101, 1'b0, 32'h0, 1'b0, 32'h00000BAD, 0, "lhu_top");

        // Both requesters streaming loads with responses always consumed.
        @(negedge clk);
        bus.req_addr[0] = 32'h10;
        bus.req_sel[0]  = 3'b010;
        bus.req_wen[0]  = 1'b0;
        bus.req_addr[1] = 32'h1FC;
        bus.req_sel[1]  = 3'b010;
        bus.req_wen[1]  = 1'b0;
        bus.req_valid   = 2'b11;
        bus.resp_ready  = 2'b11;
        ng = 0;
        for (int c = 0; c < 11; c++) begin
            #1;
            if (bus.req_ready != 2'b00) begin
                if (ng < 4) begin
                    g_idx[ng] = bus.req_ready;
                    g_cyc[ng] = c;
                end
                ng++;
            end
            @(negedge clk);
        end
        bus.req_valid = 2'b00;
        repeat (2) @(negedge clk);
        bus.resp_ready = 2'b00;
        #1;
        check("rr:grant_count", 32'(ng), 32'd4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rr:grant%0d_idx", k), 32'(g_idx[k]), (k % 2 == 0) ? 32'd1 : 32'd2);
            check($sformatf("rr:grant%0d_cycle", k), 32'(g_cyc[k]), 32'(3 * k));
        end
        check("rr:idle_valid", 32'(bus.resp_valid), 32'd0);

        // Reset asserted while a store to 0x30 is in its issue cycle.
        do_access(1, 32'h30, 3'b010, 1'b1, 32'h55667788, 1'b0, 32'h0, 0, "sw_30");
        @(negedge clk);
        bus.req_addr[0]  = 32'h30;
        bus.req_sel[0]   = 3'b010;
        bus.req_wen[0]   = 1'b1;
        bus.req_wdata[0] = 32'hCAFEF00D;
        bus.req_valid    = 2'b01;
        #1;
        check("rstiss:req_ready", 32'(bus.req_ready), 32'd1);
        wc0 = wen_count;
        @(negedge clk);
        bus.req_valid = 2'b00;
        #1;
        check("rstiss:wen_before", 32'(bus.mem_wen), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rstiss:wen_gated", 32'(bus.mem_wen), 32'd0);
        @(negedge clk);
        #1;
        check("rstiss:req_ready", 32'(bus.req_ready), 32'd0);
        check("rstiss:resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rstiss:resp_err", 32'(bus.resp_err), 32'd0);
        check("rstiss:resp_rdata", bus.resp_rdata, 32'd0);
        check("rstiss:mem_addr", bus.mem_addr, 32'd0);
        check("rstiss:mem_sel", 32'(bus.mem_sel), 32'd0);
        check("rstiss:mem_wdata", bus.mem_wdata, 32'd0);
        check("rstiss:wen_cycles", 32'(wen_count - wc0), 32'd0);
        check("rstiss:word30", mem_read(32'h30, 3'b010), 32'h55667788);
        rst_n = 1'b1;

        // Pointer is back to favouring requester 0 after reset.
        @(negedge clk);
        bus.req_wen[0] = 1'b0;
        bus.req_addr[1] = 32'h10;
        bus.req_valid  = 2'b11;
        #1;
        check("postrst:grant", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        bus.req_valid = 2'b00;
        @(negedge clk);
        #1;
        check("postrst:resp_valid", 32'(bus.resp_valid), 32'd1);
        check("postrst:resp_rdata", bus.resp_rdata, 32'h55667788);
        bus.resp_ready = 2'b01;
        @(negedge clk);
        bus.resp_ready = 2'b00;
        #1;
        check("postrst:idle_valid", 32'(bus.resp_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and access sequencer for the read/write port (port A) of the RV32I mock memory. It accepts load/store requests from the core LSU (requester 0) and from the debug/loader path (requester 1) over valid/ready handshakes, grants them round-robin, and drives the memory port for exactly one cycle per access. It accounts for the memory's one-cycle registered read latency and returns the response on a per-requester valid/ready channel. Misaligned or illegal accesses are rejected with an error response and never reach the memory.

## Interface
- Parameter `ADDR_LIMIT`, default 512: byte size of the memory. Addresses at or above this value are errors.
- `clk`, input, 1: clock. All state updates on the rising edge.
- `rst_n`, input, 1: synchronous, active-low reset.
- `req_valid`, input, [1:0]: request valid, one bit per requester.
- `req_ready`, output, [1:0]: request accepted this cycle, one bit per requester.
- `req_addr`, input, [1:0][31:0]: byte address.
- `req_wen`, input, [1:0]: 1 = store, 0 = load.
- `req_sel`, input, [1:0][2:0]: funct3 (000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu).
- `req_wdata`, input, [1:0][31:0]: store data.
- `resp_valid`, output, [1:0]: response valid, one-hot or zero.
- `resp_ready`, input, [1:0]: response consumed.
- `resp_rdata`, output, 32: load data. Shared by both requesters; qualified by `resp_valid`.
- `resp_err`, output, 1: response is an error. Qualified by `resp_valid`.
- `mem_addr`, output, 32: to memory port A address.
- `mem_sel`, output, 3: to memory port A select.
- `mem_wen`, output, 1: to memory port A write enable.
- `mem_wdata`, output, 32: to memory port A write data.
- `mem_rdata`, input, 32: from memory port A read data, registered inside the memory.

## Operation
- States: IDLE, ISSUE, RESP, ERR.
- IDLE
  - The grant goes to the requester with `req_valid` set. If both are set, it goes to the one not granted last; the pointer resets to favour requester 0.
  - `req_ready[g]` is high only for the granted requester, and only in IDLE.
  - On accept, the requester index, addr, sel, wen and wdata are latched and the last-grant pointer is updated.
  - A legal request goes to ISSUE. An illegal request goes to ERR.
- Illegal request: any of the following.
  - `req_sel` is 011, 110 or 111.
  - Store with `req_sel` 100 or 101.
  - `req_sel` 001/101 with addr[0] set.
  - `req_sel` 010 with addr[1:0] not 00.
  - addr + access size > `ADDR_LIMIT`.
- ISSUE (one cycle)
  - `mem_addr`, `mem_sel` and `mem_wdata` come from the latched values.
  - `mem_wen` equals the latched wen, gated by `rst_n`.
  - Next state is RESP.
- RESP
  - `mem_addr` and `mem_sel` stay at the latched values and `mem_wen` is 0, so `mem_rdata` stays stable.
  - `resp_valid[idx]` is 1 and `resp_err` is 0.
  - `resp_rdata` = `mem_rdata` for loads, 0 for stores.
  - Stays in RESP until `resp_ready[idx]`, then goes to IDLE.
- ERR
  - `resp_valid[idx]` is 1, `resp_err` is 1, `resp_rdata` is 0.
  - Goes to IDLE on `resp_ready[idx]`.
- Outside ISSUE, `mem_wen` is 0. `mem_addr`, `mem_sel` and `mem_wdata` hold their last latched values; after reset they are 0.
- `resp_ready` from the non-owning requester is ignored.

## Timing
- Reset values: state IDLE, `req_ready` 0, `resp_valid` 0, `resp_err` 0, `resp_rdata` 0, `mem_wen` 0, `mem_addr` 0, `mem_sel` 0, `mem_wdata` 0, grant pointer favouring requester 0.
- Legal access: accept at cycle T, ISSUE at T+1, `resp_valid` at T+2 at the earliest.
- Error access: accept at T, `resp_valid` with `resp_err` at T+1. No memory cycle occurs.
- RESP/ERR → IDLE on the cycle `resp_ready` is high. The next accept is possible the cycle after, so peak throughput is one access per 3 cycles.
- `req_valid` dropping while not ready causes no side effect.
- Reset asserted in any state returns to IDLE on the next edge and drops the in-flight response.
  - If reset coincides with ISSUE, `mem_wen` is 0 that cycle and no write occurs.

## Test plan
- Req0 `lw` addr 0x10 with memory word 0xDEADBEEF → `req_ready[0]` at T, `mem_wen`=0 at T+1, `resp_valid`=2'b01 at T+2 with `resp_rdata`=0xDEADBEEF and `resp_err`=0.
- Req1 `sb` addr 0x21 data 0x000000AA, then req1 `lbu` addr 0x21 → `mem_wen`=1 for exactly one cycle; the load returns 0x000000AA.
- Both requesters valid continuously with legal loads → grants alternate 0,1,0,1, each grant separated by 3 cycles.
- Req0 `lw` addr 0x02 (misaligned), and separately `sw` with sel 100 → `resp_err`=1 at T+1, `mem_wen` never asserts, `resp_rdata`=0.
- `resp_ready` held low for 5 cycles in RESP → `resp_valid` and `resp_rdata` stay stable; `req_ready`=0 for both requesters throughout.
- `rst_n` low during ISSUE of a store to 0x30 → `mem_wen` stays 0, memory word at 0x30 is unchanged, all outputs are at reset values after the edge.
